// File: rtl/mmcm_drp_if.sv
// DRP bus between the reconfiguration sequencer (master) and the MMCM DRP port (slave).
interface mmcm_drp_if;
    logic        den_o;
    logic        dwe_o;
    logic [6:0]  daddr_o;
    logic [15:0] di_o;
    logic [15:0] do_i;
    logic        drdy_i;

    modport master (output den_o, dwe_o, daddr_o, di_o, input do_i, drdy_i);
    modport slave  (input den_o, dwe_o, daddr_o, di_o, output do_i, drdy_i);
endinterface

// File: rtl/mmcm_drp_sequencer.sv
// MMCM reconfiguration: holds the MMCM in reset, read-modify-writes NUM_REGS DRP
// registers from an external table, releases reset and waits for a stable lock.
module mmcm_drp_sequencer #(
    parameter int NUM_REGS     = 4,
    parameter int DRP_TIMEOUT  = 255,
    parameter int LOCK_TIMEOUT = 40000
) (
    input  logic              clk160_o,
    input  logic              reset_in,
    input  logic              start_i,
    output logic [3:0]        tbl_idx_o,
    input  logic [6:0]        tbl_addr_i,
    input  logic [15:0]       tbl_mask_i,
    input  logic [15:0]       tbl_data_i,
    mmcm_drp_if.master        drp,
    output logic              mmcm_rst_o,
    input  logic              locked_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);
    localparam int CNT_MAX = (LOCK_TIMEOUT > DRP_TIMEOUT) ? LOCK_TIMEOUT : DRP_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DRP_LAST  = CW'(DRP_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]    IDX_LAST  = 4'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        IDLE, RST_ASSERT, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, LOCK_WAIT, DONE, ERROR
    } state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_hi;
    logic [15:0]   r_rmw;
    logic [3:0]    r_idx;
    logic          r_err;
    logic          w_accept, w_capture, w_idx_inc;

    always_ff @(posedge clk160_o or posedge reset_in) begin
        if (reset_in) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_idx_inc    = 1'b0;
        drp.den_o    = 1'b0;
        drp.dwe_o    = 1'b0;
        drp.daddr_o  = '0;
        drp.di_o     = '0;
        mmcm_rst_o   = 1'b0;
        done_o       = 1'b0;
        busy_o       = (r_state != IDLE);
        case (r_state)
            IDLE: if (start_i) begin
                w_accept = 1'b1;
                w_next   = RST_ASSERT;
            end
            RST_ASSERT: begin
                mmcm_rst_o = 1'b1;
                w_next     = RD_REQ;
            end
            RD_REQ: begin
                mmcm_rst_o  = 1'b1;
                drp.den_o   = 1'b1;
                drp.daddr_o = tbl_addr_i;
                w_next      = RD_WAIT;
            end
            // drdy_i on the final counted cycle still completes the access
            RD_WAIT: begin
                mmcm_rst_o = 1'b1;
                if (drp.drdy_i) begin
                    w_capture = 1'b1;
                    w_next    = WR_REQ;
                end else if (r_cnt == DRP_LAST) w_next = ERROR;
            end
            WR_REQ: begin
                mmcm_rst_o  = 1'b1;
                drp.den_o   = 1'b1;
                drp.dwe_o   = 1'b1;
                drp.daddr_o = tbl_addr_i;
                drp.di_o    = r_rmw;
                w_next      = WR_WAIT;
            end
            WR_WAIT: begin
                mmcm_rst_o = 1'b1;
                if (drp.drdy_i)              w_next = NEXT;
                else if (r_cnt == DRP_LAST)  w_next = ERROR;
            end
            NEXT: begin
                mmcm_rst_o = 1'b1;
                if (r_idx < IDX_LAST) begin
                    w_idx_inc = 1'b1;
                    w_next    = RD_REQ;
                end else w_next = LOCK_WAIT;
            end
            LOCK_WAIT: begin
                if (locked_i && r_hi == 2'd3)  w_next = DONE;
                else if (r_cnt == LOCK_LAST)   w_next = ERROR;
            end
            DONE: begin
                done_o = 1'b1;
                w_next = IDLE;
            end
            ERROR:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // r_cnt counts cycles spent in the current state; it restarts on every transition
    always_ff @(posedge clk160_o or posedge reset_in) begin
        if (reset_in) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_rmw <= '0;
            r_idx <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + 1'b1;
            r_hi  <= (r_state == LOCK_WAIT && locked_i) ? r_hi + 2'd1 : 2'd0;
            if (w_capture) r_rmw <= (drp.do_i & tbl_mask_i) | tbl_data_i;
            if (w_accept) begin
                r_idx <= '0;
                r_err <= 1'b0;
            end else begin
                if (w_idx_inc) r_idx <= r_idx + 4'd1;
                if (w_next == ERROR && r_state != ERROR) r_err <= 1'b1;
            end
        end
    end

    assign tbl_idx_o = r_idx;
    assign error_o   = r_err;
endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Bench for mmcm_drp_sequencer: DRP responder model, write scoreboard and lock stimulus.
module tb_mmcm_drp_sequencer;
    localparam int NR = 2;
    localparam int DT = 20;
    localparam int LT = 200;

    logic        clk160_o = 1'b0;
    logic        reset_in = 1'b1;
    logic        start_i  = 1'b0;
    logic        locked_i = 1'b0;
    logic [3:0]  tbl_idx_o;
    logic [6:0]  tbl_addr_i;
    logic [15:0] tbl_mask_i, tbl_data_i;
    logic        mmcm_rst_o, busy_o, done_o, error_o;

    logic [6:0]  tb_addr [16];
    logic [15:0] tb_mask [16];
    logic [15:0] tb_data [16];
    logic [15:0] drp_do = 16'h0;
    logic        mute = 1'b0;

    typedef struct { logic [6:0] addr; logic [15:0] data; } wr_t;
    wr_t sb[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_rise = 0;
    int done_cyc = 0, err_cyc = 0, last_den_cyc = 0, wr_at_fall = 0;

    mmcm_drp_if drp ();

    mmcm_drp_sequencer #(.NUM_REGS(NR), .DRP_TIMEOUT(DT), .LOCK_TIMEOUT(LT)) dut (
        .clk160_o(clk160_o), .reset_in(reset_in), .start_i(start_i), .tbl_idx_o(tbl_idx_o),
        .tbl_addr_i(tbl_addr_i), .tbl_mask_i(tbl_mask_i), .tbl_data_i(tbl_data_i),
        .drp(drp.master), .mmcm_rst_o(mmcm_rst_o), .locked_i(locked_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    assign tbl_addr_i = tb_addr[tbl_idx_o];
    assign tbl_mask_i = tb_mask[tbl_idx_o];
    assign tbl_data_i = tb_data[tbl_idx_o];

    always #5 clk160_o = ~clk160_o;
    always @(posedge clk160_o) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk160_o);
        #2;
    endtask

    task automatic push_seq();
        for (int i = 0; i < NR; i++) sb.push_back('{tb_addr[i], (drp_do & tb_mask[i]) | tb_data[i]});
    endtask

    // DRP responder (drdy 3 cycles after den) plus monitors, sampled 1ns after each edge
    initial begin
        int cd = 0;
        logic prev_den = 1'b0, prev_rst = 1'b0, prev_err = 1'b0;
        wr_t e;
        drp.drdy_i = 1'b0;
        drp.do_i   = '0;
        forever begin
            @(posedge clk160_o);
            #1;
            drp.drdy_i = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    drp.drdy_i = 1'b1;
                    drp.do_i   = drp_do;
                end
            end
            if (drp.den_o) begin
                chk("den_gap", prev_den, 1'b0);
                if (!mute) cd = 3;
                last_den_cyc = cyc;
                if (drp.dwe_o) begin
                    wr_cnt++;
                    if (sb.size() == 0) chk("wr_unexpected", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("wr_addr", drp.daddr_o, e.addr);
                        chk("wr_data", drp.di_o, e.data);
                    end
                end else rd_cnt++;
            end
            if (prev_rst && !mmcm_rst_o) wr_at_fall = wr_cnt;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!prev_err && error_o) begin
                err_rise++;
                err_cyc = cyc;
            end
            prev_den = drp.den_o;
            prev_rst = mmcm_rst_o;
            prev_err = error_o;
        end
    end

    initial begin
        int w0, r0, d0, e0, f;
        logic pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        for (int i = 0; i < 16; i++) begin
            tb_addr[i] = 7'(8 + 12 * i);
            tb_mask[i] = 16'h00FF;
            tb_data[i] = 16'h1200;
        end
        step(3);
        chk("rst_ctrl", {busy_o, done_o, error_o, mmcm_rst_o, drp.den_o, drp.dwe_o}, 6'b0);
        chk("rst_bus", {tbl_idx_o, drp.daddr_o, drp.di_o}, 27'h0);
        reset_in = 1'b0;
        step(2);
        chk("idle_busy", busy_o, 1'b0);

        // two entries, do=FFFF, mask 00FF, data 1200; lock 10 cycles after release
        drp_do = 16'hFFFF;
        push_seq();
        w0 = wr_cnt; d0 = done_cnt;
        start_i = 1'b1; step(1); start_i = 1'b0;
        chk("a_start", {busy_o, mmcm_rst_o, error_o, drp.den_o}, 4'b1100);
        chk("a_start_idx", tbl_idx_o, 4'd0);
        step(1);
        chk("a_rdreq", {drp.den_o, drp.dwe_o, drp.daddr_o}, {2'b10, tb_addr[0]});
        for (int i = 0; i < 200 && mmcm_rst_o; i++) step(1);
        chk("a_rst_fall", mmcm_rst_o, 1'b0);
        chk("a_wr_before_fall", wr_at_fall - w0, NR);
        f = cyc;
        step(10); locked_i = 1'b1;
        for (int i = 0; i < 50 && done_cnt == d0; i++) step(1);
        chk("a_done_cyc", done_cyc, f + 14);
        step(1);
        chk("a_after_done", {done_o, busy_o, error_o}, 3'b0);
        step(3);
        chk("a_done_pulses", done_cnt - d0, 1);
        chk("a_writes", wr_cnt - w0, NR);
        chk("a_sb_empty", sb.size(), 0);
        locked_i = 1'b0;

        // first read never answered -> DRP timeout, no write
        mute = 1'b1;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_rise;
        start_i = 1'b1; step(1); start_i = 1'b0;
        for (int i = 0; i < 100 && err_rise == e0; i++) step(1);
        chk("b_err_cyc", err_cyc, last_den_cyc + 1 + DT);
        chk("b_err_state", {error_o, mmcm_rst_o, busy_o}, 3'b101);
        step(1);
        chk("b_idle", {error_o, busy_o}, 2'b10);
        chk("b_reads", rd_cnt - r0, 1);
        chk("b_no_write", wr_cnt - w0, 0);
        mute = 1'b0;

        // lock pattern 1,1,1,0,1,1,1,1 -> done only after the final run
        drp_do = 16'h5A3C;
        tb_mask[0] = 16'hF0F0; tb_data[0] = 16'h0102;
        tb_mask[1] = 16'h0F0F; tb_data[1] = 16'h8000;
        push_seq();
        d0 = done_cnt;
        start_i = 1'b1; step(1); start_i = 1'b0;
        chk("c_err_clear", error_o, 1'b0);
        for (int i = 0; i < 200 && (busy_o && mmcm_rst_o || !busy_o); i++) step(1);
        f = cyc;
        for (int k = 0; k < 8; k++) begin
            locked_i = pat[k];
            step(1);
        end
        chk("c_done_cyc", done_cyc, f + 8);
        chk("c_done_pulses", done_cnt - d0, 1);
        chk("c_sb_empty", sb.size(), 0);
        locked_i = 1'b0;
        step(2);

        // lock never arrives -> lock timeout
        push_seq();
        d0 = done_cnt; e0 = err_rise;
        start_i = 1'b1; step(1); start_i = 1'b0;
        for (int i = 0; i < 200 && mmcm_rst_o; i++) step(1);
        f = cyc;
        for (int i = 0; i < LT + 20 && err_rise == e0; i++) step(1);
        chk("d_err_cyc", err_cyc, f + LT);
        chk("d_err_state", {error_o, mmcm_rst_o, done_cnt - d0 == 0}, 3'b101);
        step(2);

        // start during WR_WAIT ignored, then reset during entry 1 RD_WAIT
        push_seq();
        w0 = wr_cnt; r0 = rd_cnt;
        start_i = 1'b1; step(1); start_i = 1'b0;
        for (int i = 0; i < 100 && wr_cnt == w0; i++) step(1);
        step(1);
        start_i = 1'b1; step(1); start_i = 1'b0;
        for (int i = 0; i < 100 && rd_cnt != r0 + 2; i++) step(1);
        step(1);
        chk("e_idx_before_rst", tbl_idx_o, 4'd1);
        reset_in = 1'b1;
        #1;
        chk("e_rst_ctrl", {busy_o, done_o, error_o, mmcm_rst_o, drp.den_o, drp.dwe_o}, 6'b0);
        chk("e_rst_bus", {tbl_idx_o, drp.daddr_o, drp.di_o}, 27'h0);
        step(6);
        chk("e_no_access", {rd_cnt - r0, wr_cnt - w0}, {32'd2, 32'd1});
        sb.delete();
        reset_in = 1'b0;
        step(5);
        chk("e_not_queued", busy_o, 1'b0);
        reset_in = 1'b1;
        step(2);
        push_seq();
        w0 = wr_cnt; d0 = done_cnt;
        reset_in = 1'b0; start_i = 1'b1;
        #1;
        chk("e_start_no_async", busy_o, 1'b0);
        step(1); start_i = 1'b0;
        chk("e_restart", {busy_o, mmcm_rst_o, tbl_idx_o}, {2'b11, 4'd0});
        for (int i = 0; i < 200 && mmcm_rst_o; i++) step(1);
        locked_i = 1'b1;
        for (int i = 0; i < 50 && done_cnt == d0; i++) step(1);
        chk("e_done", done_cnt - d0, 1);
        chk("e_writes", wr_cnt - w0, NR);
        chk("e_sb_empty", sb.size(), 0);
        locked_i = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
